pipe_stage_hs: RTL and testbench

Parametrised pipeline stage register with a valid/ready handshake, a flush, and an optional two-entry skid buffer. It is the successor to the plain enable/clear pipeline flop. Back-pressure propagates per beat instead of through a global stall. Flush discards in-flight state. In skid mode, `in_ready` is cut into a register so long stall chains do not form combinational ready paths. It sits between CPU pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB) and is instantiated once per stage boundary.

---
 rtl/pipe_pkg.sv | 14 +
 rtl/pipe_stage_hs.sv | 106 ++++++++++
 tb/tb_pipe_stage_hs.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Purpose: shared state encoding for the handshaked pipeline stage register.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
// Contents: ST_* state constants; the state value doubles as the occupancy count.
package pipe_pkg;

    typedef logic [1:0] state_t;

    // The encoding equals the number of stored beats, so occupancy is the state register.
    localparam state_t ST_EMPTY = 2'd0;
    localparam state_t ST_ONE   = 2'd1;
    localparam state_t ST_TWO   = 2'd2;

endpackage

// File: rtl/pipe_stage_hs.sv
// Purpose: valid/ready pipeline stage register with flush, optional two-entry skid buffer.
// Latency: 1 cycle; a beat accepted at edge N is presented on out_* after edge N.
// Backpressure: per beat; SKID=1 registers in_ready (skid entry absorbs the late beat), SKID=0 passes out_ready to in_ready combinationally.
//
// Ports:
//   clk, rst       - clock and synchronous active-low reset
//   flush          - discard every stored beat (a beat leaving the same cycle is still delivered)
//   in_valid/in_ready/in_data    - upstream handshake and payload
//   out_valid/out_ready/out_data - downstream handshake and payload of the oldest beat
//   occupancy      - number of stored beats (0..2, or 0..1 when SKID=0)
module pipe_stage_hs #(
    parameter int WIDTH = 32,
    parameter int SKID  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);
    import pipe_pkg::*;

    state_t           state;
    logic [WIDTH-1:0] m_q;
    logic             in_fire;
    logic             out_fire;

    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    // Both outputs come straight from registers in either mode.
    assign out_valid = (state != ST_EMPTY);
    assign out_data  = m_q;
    assign occupancy = state;

    generate
        if (SKID != 0) begin : g_skid
            logic [WIDTH-1:0] s_q;

            // Decoded from the state register alone, so no path from out_ready or flush.
            assign in_ready = (state != ST_TWO);

            always_ff @(posedge clk) begin
                if (!rst) begin
                    state <= ST_EMPTY;
                    m_q   <= '0;
                    s_q   <= '0;
                end else if (flush) begin
                    // Data registers keep their contents; they are don't-care once empty.
                    state <= ST_EMPTY;
                end else begin
                    case (state)
                        ST_EMPTY: begin
                            if (in_fire) begin
                                state <= ST_ONE;
                                m_q   <= in_data;
                            end
                        end
                        ST_ONE: begin
                            if (in_fire && out_fire) begin
                                m_q <= in_data;
                            end else if (in_fire) begin
                                // Downstream stalled after in_ready was already promised.
                                state <= ST_TWO;
                                s_q   <= in_data;
                            end else if (out_fire) begin
                                state <= ST_EMPTY;
                            end
                        end
                        ST_TWO: begin
                            // in_ready is low here, so only the drain can happen.
                            if (out_fire) begin
                                state <= ST_ONE;
                                m_q   <= s_q;
                            end
                        end
                        default: state <= ST_EMPTY;
                    endcase
                end
            end
        end else begin : g_single
            // Refill in the same cycle the held beat leaves.
            assign in_ready = ~out_valid | out_ready;

            always_ff @(posedge clk) begin
                if (!rst) begin
                    state <= ST_EMPTY;
                    m_q   <= '0;
                end else if (flush) begin
                    state <= ST_EMPTY;
                end else if (in_fire) begin
                    state <= ST_ONE;
                    m_q   <= in_data;
                end else if (out_fire) begin
                    state <= ST_EMPTY;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_pipe_stage_hs.sv
module tb_pipe_stage_hs;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic [W-1:0] in_data;

    // SKID=1 instance
    logic         iv1, ir1, ov1, or1;
    logic [W-1:0] od1;
    logic [1:0]   occ1;
    // SKID=0 instance
    logic         iv0, ir0, ov0, or0;
    logic [W-1:0] od0;
    logic [1:0]   occ0;

    int passed = 0;
    int total  = 0;

    logic [W-1:0] q1[$];
    logic [W-1:0] q0[$];

    always #5 clk = ~clk;

    pipe_stage_hs #(.WIDTH(W), .SKID(1)) u1 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(iv1), .in_ready(ir1), .in_data(in_data),
        .out_valid(ov1), .out_ready(or1), .out_data(od1),
        .occupancy(occ1)
    );

    pipe_stage_hs #(.WIDTH(W), .SKID(0)) u0 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(iv0), .in_ready(ir0), .in_data(in_data),
        .out_valid(ov0), .out_ready(or0), .out_data(od0),
        .occupancy(occ0)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Inputs change 1 time unit after the rising edge; checks happen on the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Scoreboard monitors: pop on every delivered beat, then apply flush/reset, then record accepts.
    always @(negedge clk) begin
        if (ov1 && or1) begin
            if (q1.size() == 0) begin
                total++;
                $display("FAIL u1_spurious: got beat 0x%0h expected none at %0t", od1, $time);
            end else begin
                chk("u1_data", int'(od1), int'(q1.pop_front()));
            end
        end
        if (!rst || flush) q1.delete();
        else if (iv1 && ir1) q1.push_back(in_data);
    end

    always @(negedge clk) begin
        if (ov0 && or0) begin
            if (q0.size() == 0) begin
                total++;
                $display("FAIL u0_spurious: got beat 0x%0h expected none at %0t", od0, $time);
            end else begin
                chk("u0_data", int'(od0), int'(q0.pop_front()));
            end
        end
        if (!rst || flush) q0.delete();
        else if (iv0 && ir0) q0.push_back(in_data);
    end

    initial begin
        // Reset with a beat presented: it must be dropped.
        rst = 1'b0; flush = 1'b0; in_data = 8'hAA;
        iv1 = 1'b1; iv0 = 1'b1; or1 = 1'b1; or0 = 1'b1;
        tick();
        tick();
        rst = 1'b1; iv1 = 1'b0; iv0 = 1'b0;
        mid();
        chk("rst_u1_out_valid", ov1, 0);
        chk("rst_u1_occ", occ1, 0);
        chk("rst_u1_in_ready", ir1, 1);
        chk("rst_u1_out_data", od1, 0);
        chk("rst_u0_out_valid", ov0, 0);
        chk("rst_u0_occ", occ0, 0);
        chk("rst_u0_in_ready", ir0, 1);
        chk("rst_u0_out_data", od0, 0);
        tick();

        // Back-to-back streaming 0x1..0x8 into both instances.
        for (int i = 1; i <= 8; i++) begin
            iv1 = 1'b1; iv0 = 1'b1; in_data = W'(i);
            mid();
            if (i == 2) begin
                chk("stream_first_valid", ov1, 1);
                chk("stream_first_data", od1, 1);
            end
            if (i >= 2) begin
                chk("stream_u1_occ", occ1, 1);
                chk("stream_u0_occ", occ0, 1);
            end
            tick();
        end
        iv1 = 1'b0; iv0 = 1'b0;
        mid();
        chk("stream_tail_occ", occ1, 1);
        tick();
        mid();
        chk("stream_drained_u1", occ1, 0);
        chk("stream_drained_u0", occ0, 0);

        // Stall with skid capture (SKID=1 only).
        tick();
        iv1 = 1'b1; in_data = 8'h10; or1 = 1'b1;
        tick();
        in_data = 8'h11; or1 = 1'b0;
        mid();
        chk("stall_occ_before", occ1, 1);
        chk("stall_in_ready_before", ir1, 1);
        tick();
        in_data = 8'h12;
        mid();
        chk("stall_occ_two", occ1, 2);
        chk("stall_in_ready_low", ir1, 0);
        chk("stall_out_valid", ov1, 1);
        chk("stall_out_data_held", od1, 8'h10);
        tick();
        or1 = 1'b1;
        tick();
        tick();
        iv1 = 1'b0;
        tick();
        mid();
        chk("stall_drained", occ1, 0);

        // Flush while full; the presented 0x22 must never appear.
        tick();
        or1 = 1'b0; iv1 = 1'b1; in_data = 8'h20;
        tick();
        in_data = 8'h21;
        tick();
        in_data = 8'h22; flush = 1'b1;
        mid();
        chk("flush_occ_full", occ1, 2);
        chk("flush_in_ready_ungated", ir1, 0);
        tick();
        flush = 1'b0; iv1 = 1'b0;
        mid();
        chk("flush_out_valid", ov1, 0);
        chk("flush_occ", occ1, 0);

        // Flush in ONE with an accepted beat: that beat is discarded.
        tick();
        iv1 = 1'b1; in_data = 8'h23;
        tick();
        in_data = 8'h24; flush = 1'b1;
        mid();
        chk("flush1_in_ready", ir1, 1);
        tick();
        flush = 1'b0; iv1 = 1'b0; or1 = 1'b1;
        mid();
        chk("flush1_out_valid", ov1, 0);
        chk("flush1_occ", occ1, 0);

        // Flush coinciding with out_fire: 0x30 still counts as delivered.
        tick();
        iv1 = 1'b1; in_data = 8'h30;
        tick();
        iv1 = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        mid();
        chk("flush_fire_out_valid", ov1, 0);

        // SKID=0: combinational in_ready and replace-in-place.
        tick();
        iv0 = 1'b1; or0 = 1'b1; in_data = 8'h40;
        tick();
        in_data = 8'h41; or0 = 1'b0;
        mid();
        chk("s0_in_ready_stall", ir0, 0);
        chk("s0_out_data_held", od0, 8'h40);
        tick();
        or0 = 1'b1;
        mid();
        chk("s0_in_ready_go", ir0, 1);
        tick();
        iv0 = 1'b0;
        mid();
        chk("s0_replace_occ", occ0, 1);
        chk("s0_replace_data", od0, 8'h41);
        tick();
        mid();
        chk("s0_drained", occ0, 0);
        tick();

        mid();
        chk("u1_queue_empty", q1.size(), 0);
        chk("u0_queue_empty", q0.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
